// File: rtl/swi_byte_entry_if.sv
// Switch-entry bus: raw switch bank in, assembled byte, strobe, counter and LED status out.
// The master drives the switches; the entry block is the slave.
interface swi_byte_entry_if #(
    parameter int NBITS_SW = 8
);
    logic [NBITS_SW-1:0] SWI;
    logic [7:0]          data_out;
    logic                data_valid;
    logic [7:0]          byte_count;
    logic [NBITS_SW-1:0] LED;

    modport master (
        output SWI,
        input  data_out,
        input  data_valid,
        input  byte_count,
        input  LED
    );

    modport slave (
        input  SWI,
        output data_out,
        output data_valid,
        output byte_count,
        output LED
    );
endinterface

// File: rtl/swi_byte_entry.sv
// Two-nibble byte entry from board switches: synchronise, debounce, detect key presses,
// assemble {hi, lo} on the enter key, and mirror progress on the LEDs.
module swi_byte_entry #(
    parameter int NBITS_SW  = 8,
    parameter int DB_CYCLES = 3,
    parameter int CNT_BITS  = 4
) (
    input  logic              clk_2,
    input  logic              reset,
    swi_byte_entry_if.slave   bus
);
    localparam logic [CNT_BITS-1:0] DB_LAST = CNT_BITS'(DB_CYCLES - 1);

    typedef enum logic {
        S_HI = 1'b0,
        S_LO = 1'b1
    } state_t;

    logic [NBITS_SW-1:0] s1_q;
    logic [NBITS_SW-1:0] s2_q;
    logic [NBITS_SW-1:0] db_q;
    logic [NBITS_SW-1:0] db_dly_q;

    state_t              state_q;
    logic [3:0]          hi_nib_q;
    logic [7:0]          data_out_q;
    logic                data_valid_q;
    logic [7:0]          byte_count_q;
    logic [NBITS_SW-1:0] led_q;

    logic enter_p;
    logic clear_p;
    logic capture_hi;
    logic capture_lo;
    logic byte_ready_d;
    logic state_lo_d;

    always_ff @(posedge clk_2 or posedge reset) begin
        if (reset) begin
            s1_q     <= '0;
            s2_q     <= '0;
            db_dly_q <= '0;
        end else begin
            s1_q     <= bus.SWI;
            s2_q     <= s1_q;
            db_dly_q <= db_q;
        end
    end

    // Each bit only flips after s2 has disagreed with it for DB_CYCLES consecutive edges.
    generate
        for (genvar gi = 0; gi < NBITS_SW; gi++) begin : g_db
            logic [CNT_BITS-1:0] cnt_q;

            always_ff @(posedge clk_2 or posedge reset) begin
                if (reset) begin
                    cnt_q    <= '0;
                    db_q[gi] <= 1'b0;
                end else if (s2_q[gi] == db_q[gi]) begin
                    cnt_q    <= '0;
                end else if (cnt_q == DB_LAST) begin
                    db_q[gi] <= s2_q[gi];
                    cnt_q    <= '0;
                end else begin
                    cnt_q    <= cnt_q + 1'b1;
                end
            end
        end
    endgenerate

    assign enter_p = db_q[7] & ~db_dly_q[7];
    assign clear_p = db_q[6] & ~db_dly_q[6];

    // Clear dominates: an enter arriving with a clear is simply dropped.
    assign capture_hi   = enter_p & ~clear_p & (state_q == S_HI);
    assign capture_lo   = enter_p & ~clear_p & (state_q == S_LO);
    assign byte_ready_d = capture_lo | (led_q[5] & ~clear_p);
    assign state_lo_d   = capture_hi | ((state_q == S_LO) & ~capture_lo & ~clear_p);

    always_ff @(posedge clk_2 or posedge reset) begin
        if (reset) begin
            state_q      <= S_HI;
            hi_nib_q     <= 4'h0;
            data_out_q   <= 8'h00;
            data_valid_q <= 1'b0;
            byte_count_q <= 8'h00;
            led_q        <= '0;
        end else begin
            data_valid_q <= 1'b0;
            if (clear_p) begin
                state_q  <= S_HI;
                hi_nib_q <= 4'h0;
            end else if (enter_p) begin
                case (state_q)
                    S_HI: begin
                        hi_nib_q <= db_q[3:0];
                        state_q  <= S_LO;
                    end
                    S_LO: begin
                        data_out_q   <= {hi_nib_q, db_q[3:0]};
                        data_valid_q <= 1'b1;
                        byte_count_q <= byte_count_q + 8'd1;
                        state_q      <= S_HI;
                    end
                    default: state_q <= S_HI;
                endcase
            end
            led_q <= {db_q[7], db_q[6], byte_ready_d, state_lo_d, db_q[3:0]};
        end
    end

    assign bus.data_out   = data_out_q;
    assign bus.data_valid = data_valid_q;
    assign bus.byte_count = byte_count_q;
    assign bus.LED        = led_q;
endmodule

// File: tb/tb_swi_byte_entry.sv
// Directed bench for swi_byte_entry: stimulus pushes expected {data_out, byte_count}
// into a queue, a monitor pops and compares on every data_valid strobe.
module tb_swi_byte_entry;
    logic clk;
    logic reset;

    swi_byte_entry_if #(.NBITS_SW(8)) bus ();

    swi_byte_entry #(
        .NBITS_SW (8),
        .DB_CYCLES(3),
        .CNT_BITS (4)
    ) dut (
        .clk_2(clk),
        .reset(reset),
        .bus  (bus.slave)
    );

    int n_checks = 0;
    int n_fail   = 0;
    logic [15:0] exp_q[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end else begin
            $display("ok   %s: 0x%0h at %0t", name, act, $time);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic enter_nib(input logic [3:0] n);
        bus.SWI = {4'h0, n}; cyc(8);
        bus.SWI = {4'h8, n}; cyc(8);
        bus.SWI = {4'h0, n}; cyc(8);
    endtask

    task automatic press_clear();
        bus.SWI = 8'h40; cyc(8);
        bus.SWI = 8'h00; cyc(8);
    endtask

    task automatic push_exp(input logic [7:0] d, input logic [7:0] c);
        exp_q.push_back({d, c});
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        logic [15:0] e;
        if (!reset && bus.data_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_valid: data_out=0x%0h byte_count=%0d with no byte expected at %0t",
                         bus.data_out, bus.byte_count, $time);
            end else begin
                e = exp_q.pop_front();
                check("sb_data_out", {24'h0, bus.data_out}, {24'h0, e[15:8]});
                check("sb_byte_count", {24'h0, bus.byte_count}, {24'h0, e[7:0]});
            end
        end
    end

    initial begin
        logic glitch_seen;
        bus.SWI = 8'h00;
        reset   = 1'b1;
        cyc(3);
        reset = 1'b0;
        cyc(10);
        check("rst_data_out", {24'h0, bus.data_out}, 32'h0);
        check("rst_valid", {31'h0, bus.data_valid}, 32'h0);
        check("rst_count", {24'h0, bus.byte_count}, 32'h0);
        check("rst_led", {24'h0, bus.LED}, 32'h0);

        // Basic entry A then 5
        enter_nib(4'hA);
        check("hi_led_lo_state", {31'h0, bus.LED[4]}, 32'h1);
        check("hi_led_nib", {28'h0, bus.LED[3:0]}, 32'hA);
        push_exp(8'hA5, 8'd1);
        enter_nib(4'h5);
        check("byte1_led4", {31'h0, bus.LED[4]}, 32'h0);
        check("byte1_ready", {31'h0, bus.LED[5]}, 32'h1);
        check("byte1_data", {24'h0, bus.data_out}, 32'hA5);
        check("byte1_count", {24'h0, bus.byte_count}, 32'h1);

        // Glitch rejection
        bus.SWI = 8'h00; cyc(8);
        bus.SWI = 8'h80; cyc(2);
        bus.SWI = 8'h00; cyc(8);
        check("glitch_enter_led7", {31'h0, bus.LED[7]}, 32'h0);
        check("glitch_enter_state", {31'h0, bus.LED[4]}, 32'h0);
        glitch_seen = 1'b0;
        bus.SWI = 8'h0F; cyc(1);
        if (bus.LED[3:0] != 4'h0) glitch_seen = 1'b1;
        cyc(1);
        bus.SWI = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (bus.LED[3:0] != 4'h0) glitch_seen = 1'b1;
            cyc(1);
        end
        check("glitch_nibble", {31'h0, glitch_seen}, 32'h0);

        // Clear mid-entry
        enter_nib(4'h3);
        check("clr_pre_state", {31'h0, bus.LED[4]}, 32'h1);
        press_clear();
        check("clr_state", {31'h0, bus.LED[4]}, 32'h0);
        check("clr_ready", {31'h0, bus.LED[5]}, 32'h0);
        check("clr_keeps_data", {24'h0, bus.data_out}, 32'hA5);
        enter_nib(4'h7);
        push_exp(8'h71, 8'd2);
        enter_nib(4'h1);
        check("clr_byte_count", {24'h0, bus.byte_count}, 32'h2);

        // Simultaneous clear and enter in S_LO
        enter_nib(4'h9);
        check("sim_pre_state", {31'h0, bus.LED[4]}, 32'h1);
        bus.SWI = 8'hC2; cyc(8);
        bus.SWI = 8'h02; cyc(8);
        check("sim_state", {31'h0, bus.LED[4]}, 32'h0);
        check("sim_ready", {31'h0, bus.LED[5]}, 32'h0);
        check("sim_count", {24'h0, bus.byte_count}, 32'h2);
        check("sim_data", {24'h0, bus.data_out}, 32'h71);

        // Wrap: restart from zero, then 256 bytes
        bus.SWI = 8'h00;
        reset = 1'b1; cyc(2);
        reset = 1'b0; cyc(8);
        for (int i = 0; i < 256; i++) begin
            logic [7:0] b;
            b = 8'(i);
            push_exp(b, 8'(i + 1));
            enter_nib(b[7:4]);
            enter_nib(b[3:0]);
        end
        check("wrap_count", {24'h0, bus.byte_count}, 32'h0);
        check("wrap_data", {24'h0, bus.data_out}, 32'hFF);

        // Async reset between edges during S_LO
        enter_nib(4'h4);
        check("areset_pre_state", {31'h0, bus.LED[4]}, 32'h1);
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check("areset_data", {24'h0, bus.data_out}, 32'h0);
        check("areset_count", {24'h0, bus.byte_count}, 32'h0);
        check("areset_led", {24'h0, bus.LED}, 32'h0);
        check("areset_valid", {31'h0, bus.data_valid}, 32'h0);
        bus.SWI = 8'h00;
        cyc(3);
        reset = 1'b0;
        cyc(10);
        check("post_reset_state", {31'h0, bus.LED[4]}, 32'h0);

        check("sb_pending", exp_q.size(), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/swi_byte_entry.md
Name: swi_byte_entry

Overview:
- Input-side counterpart of the board display path: consumes the raw `SWI` switches rather than driving `SEG`/`LED` from internal state.
- Synchronises and debounces every switch bit, then detects press edges on the enter and clear keys.
- Assembles two 4-bit nibbles from `SWI[3:0]` into a byte, delivered with a one-cycle valid strobe.
- Mirrors its entry state on `LED`, so the operator sees progress on the board.

Parameters:
- NBITS_SW, 8, width of switch bank and `LED` bus (fixed at 8; bit assignments below depend on it).
- DB_CYCLES, 3, consecutive stable cycles required before a debounced bit changes (legal range 1..15).
- CNT_BITS, 4, width of each per-bit debounce counter (must hold DB_CYCLES-1).

Ports:
- clk_2  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- SWI  input  8  raw switches: [3:0] nibble data, [6] clear key, [7] enter key, [5:4] unused.
- data_out  output  8  last assembled byte {high nibble, low nibble}.
- data_valid  output  1  one-cycle strobe: data_out updated this cycle.
- byte_count  output  8  number of bytes assembled, wraps 255->0.
- LED  output  8  status display (see Behaviour).

Behaviour:
- Reset (async, active-high): all flops clear immediately.
  - Sync stages, debounced bits, counters and edge-history flops go to 0.
  - state=S_HI, hi_nib=0, data_out=0, data_valid=0, byte_count=0, LED=0.
- Synchroniser: two flops per SWI bit, giving s1 then s2.
- Debounce, per bit, evaluated every cycle:
  - s2==db: cnt<=0.
  - s2!=db and cnt==DB_CYCLES-1: db<=s2, cnt<=0.
  - Otherwise: cnt<=cnt+1.
  - Net latency: an SWI change held stable is reflected in db on the (DB_CYCLES+2)th rising edge after the change.
  - A pulse at s2 shorter than DB_CYCLES cycles never reaches db.
- Edge detect:
  - db_q is a registered copy of db.
  - enter_p = db[7] & ~db_q[7]; clear_p = db[6] & ~db_q[6].
  - Each pulse is high for exactly one cycle per press; releases generate nothing.
- FSM (2 states), evaluated on each rising edge:
  - S_HI, enter_p: hi_nib<=db[3:0]; go to S_LO.
  - S_LO, enter_p: data_out<={hi_nib, db[3:0]}; data_valid<=1; byte_count<=byte_count+1 (mod 256); go to S_HI.
  - clear_p in either state: go to S_HI; hi_nib<=0. data_out and byte_count are unchanged.
  - clear_p and enter_p in the same cycle: clear wins, the enter is dropped.
  - No pulse: hold state.
- data_valid is high only in the cycle following the completing edge; otherwise 0.
- Holding enter produces exactly one capture; a new capture requires release then press.
- LED mapping, registered, updated every cycle:
  - LED[3:0] = db[3:0], a live preview of the debounced nibble.
  - LED[4] = 1 in S_LO.
  - LED[5] = byte_ready: set when data_valid is set, cleared by clear_p; if both occur in the same cycle, set wins.
  - LED[6] = db[6].
  - LED[7] = db[7].
- Reset asserted mid-entry: the partial byte is discarded, state returns to S_HI, and all outputs are 0 while reset is high.
- After reset deasserts, switches already held high are seen as presses once debounced, because db starts at 0. This is intended.

Test Plan:
- Reset with SWI=8'h00, release, idle 10 cycles -> all outputs 0, state S_HI, data_valid never high.
- Basic entry, DB_CYCLES=3:
  - SWI=8'h0A, then enter (SWI[7]) pressed and released, each level held 8 cycles -> LED[4]=1.
  - SWI=8'h05, then enter pressed and released -> one data_valid pulse, data_out=8'hA5, byte_count=1, LED[5]=1.
- Glitch rejection: SWI[7] high for 2 cycles then low -> no db change, no state change; SWI[3:0] changed 0->F for 2 cycles -> LED[3:0] stays 0.
- Clear mid-entry:
  - Enter high nibble 3, then press clear -> state S_HI, LED[5]=0.
  - Then enter 7 and 1 -> data_out=8'h71 (not 8'h3x), byte_count +1 only.
- Simultaneous keys: SWI[7] and SWI[6] rise on the same edge while in S_LO -> state S_HI, no data_valid, byte_count unchanged.
- Wrap and async reset:
  - 256 complete byte entries -> byte_count returns to 0 on the 256th data_valid.
  - Assert reset between edges during S_LO -> all outputs 0 before the next clk_2 edge.
